// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared register selects, data width and parameter legality check for the I/O blocks
package io_pkg;

  localparam logic REG_LEVEL = 1'b0;
  localparam logic REG_EVENT = 1'b1;
  localparam int   IO_DATA_W = 16;

  function automatic bit params_ok(input int num_buttons, input int num_switches,
                                   input int db_cycles, input int repeat_delay,
                                   input int repeat_period);
    return (num_buttons + num_switches <= IO_DATA_W) && (db_cycles >= 1) &&
           ((repeat_delay == 0) || (repeat_period >= 1));
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// rtl/debounce_ch.sv - counter debounce for one synchronised button, with a one-cycle rise pulse
module debounce_ch #(
  parameter int DB_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic in_sync,
  output logic db_out,
  output logic rise
);

  localparam int            CW   = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic [CW-1:0] cnt;

  // rise is registered alongside db_out, so it is high during the first cycle db_out reads 1
  always_ff @(posedge clk) begin
    if (rst) begin
      db_out <= 1'b0;
      rise   <= 1'b0;
      cnt    <= '0;
    end else begin
      rise <= 1'b0;
      if (in_sync == db_out) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        db_out <= ~db_out;
        rise   <= ~db_out;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/input_event_unit.sv
// rtl/input_event_unit.sv - front-panel buttons/switches: sync, debounce, sticky events, hold-repeat, irq
module input_event_unit
  import io_pkg::*;
#(
  parameter int NUM_BUTTONS   = 5,
  parameter int NUM_SWITCHES  = 6,
  parameter int DB_CYCLES     = 65536,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_PERIOD = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_BUTTONS-1:0]  buttons_raw,
  input  logic [NUM_SWITCHES-1:0] switches_raw,
  input  logic                    rd_en,
  input  logic                    rd_sel,
  output logic [IO_DATA_W-1:0]    data_out,
  output logic                    irq
);

  localparam int NCH = NUM_BUTTONS + NUM_SWITCHES;

  if (!params_ok(NUM_BUTTONS, NUM_SWITCHES, DB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) begin : g_bad_params
    $error("input_event_unit: illegal parameter combination");
  end

  logic [NUM_BUTTONS-1:0]  btn_s1, btn_s2, db, rise, tick;
  logic [NUM_SWITCHES-1:0] sw_s1, sw_s2, sw_prev;
  logic [IO_DATA_W-1:0]    level, ev_set, ev_clr, flags, flags_next;

  // sw_prev restarts at 0 so switches already on at reset report one power-up event
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1  <= '0;
      btn_s2  <= '0;
      sw_s1   <= '0;
      sw_s2   <= '0;
      sw_prev <= '0;
    end else begin
      btn_s1  <= buttons_raw;
      btn_s2  <= btn_s1;
      sw_s1   <= switches_raw;
      sw_s2   <= sw_s1;
      sw_prev <= sw_s2;
    end
  end

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_db
    debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk    (clk),
      .rst    (rst),
      .in_sync(btn_s2[i]),
      .db_out (db[i]),
      .rise   (rise[i])
    );
  end

  if (REPEAT_DELAY > 0) begin : g_rep
    localparam int            RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int            RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DLY  = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] PER  = RW'(REPEAT_PERIOD);

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
      logic [RW-1:0] hold;
      logic          rpt;

      // hold counts cycles since the rise; after the first tick it restarts on the period target
      assign tick[i] = db[i] && (hold == (rpt ? PER : DLY));

      always_ff @(posedge clk) begin
        if (rst || !db[i]) begin
          hold <= '0;
          rpt  <= 1'b0;
        end else if (tick[i]) begin
          hold <= RW'(1);
          rpt  <= 1'b1;
        end else begin
          hold <= hold + RW'(1);
        end
      end
    end
  end else begin : g_no_rep
    assign tick = '0;
  end

  always_comb begin
    level  = '0;
    ev_set = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      level[i]  = db[i];
      ev_set[i] = rise[i] | tick[i];
    end
    for (int j = 0; j < NUM_SWITCHES; j++) begin
      level[NCH-1-j]  = sw_s2[j];
      ev_set[NCH-1-j] = sw_s2[j] ^ sw_prev[j];
    end
    ev_clr     = (rd_en && (rd_sel == REG_EVENT)) ? flags : '0;
    flags_next = (flags & ~ev_clr) | ev_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags    <= '0;
      irq      <= 1'b0;
      data_out <= '0;
    end else begin
      flags <= flags_next;
      irq   <= |flags;
      if (rd_en) begin
        data_out <= (rd_sel == REG_EVENT) ? flags : level;
      end
    end
  end

endmodule

// File: tb/tb_input_event_unit.sv
// tb/tb_input_event_unit.sv - directed self-checking bench with a scoreboard of expected read words
module tb_input_event_unit;
  import io_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  buttons_raw = '0;
  logic [5:0]  switches_raw = '0;
  logic        rd_en = 1'b0;
  logic        rd_sel = 1'b0;
  logic [15:0] data_out, data_r;
  logic        irq, irq_r;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   tick_q[$];

  always #5 clk = ~clk;

  input_event_unit #(
    .NUM_BUTTONS(5), .NUM_SWITCHES(6), .DB_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(0)
  ) dut (
    .clk(clk), .rst(rst), .buttons_raw(buttons_raw), .switches_raw(switches_raw),
    .rd_en(rd_en), .rd_sel(rd_sel), .data_out(data_out), .irq(irq)
  );

  input_event_unit #(
    .NUM_BUTTONS(5), .NUM_SWITCHES(6), .DB_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
  ) dut_r (
    .clk(clk), .rst(rst), .buttons_raw(buttons_raw), .switches_raw(switches_raw),
    .rd_en(rd_en), .rd_sel(rd_sel), .data_out(data_r), .irq(irq_r)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one read: strobe for a single edge, compare data_out on the following falling edge
  task automatic rd(input logic sel, input logic [15:0] exp, input string tag);
    exp_t e;
    @(negedge clk);
    rd_en  = 1'b1;
    rd_sel = sel;
    e.tag  = tag;
    e.exp  = exp;
    sb.push_back(e);
    @(negedge clk);
    rd_en = 1'b0;
    e = sb.pop_front();
    check(e.tag, {16'h0, data_out}, {16'h0, e.exp});
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", {16'h0, data_out}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_data_r", {16'h0, data_r}, 32'h0);
    check("rst_irq_r", {31'h0, irq_r}, 32'h0);
    rst = 1'b0;
    rd(REG_LEVEL, 16'h0000, "rst_level");

    // button 0 bounces then settles high
    @(negedge clk) buttons_raw[0] = 1'b1;
    @(negedge clk) buttons_raw[0] = 1'b0;
    @(negedge clk) buttons_raw[0] = 1'b1;
    repeat (12) @(negedge clk);
    check("db_irq_set", {31'h0, irq}, 32'h1);
    rd(REG_EVENT, 16'h0001, "db_event");
    @(negedge clk);
    check("db_irq_clr", {31'h0, irq}, 32'h0);
    rd(REG_EVENT, 16'h0000, "db_event_again");
    rd(REG_LEVEL, 16'h0001, "db_level");
    buttons_raw[0] = 1'b0;
    repeat (10) @(negedge clk);
    rd(REG_EVENT, 16'h0000, "db_fall_no_event");
    rd(REG_LEVEL, 16'h0000, "db_level_low");

    // switch bit mapping and both transition directions
    switches_raw = 6'b000001;
    repeat (5) @(negedge clk);
    rd(REG_LEVEL, 16'h0400, "sw0_level");
    rd(REG_EVENT, 16'h0400, "sw0_event");
    switches_raw = 6'b100000;
    repeat (5) @(negedge clk);
    rd(REG_LEVEL, 16'h0020, "sw5_level");
    rd(REG_EVENT, 16'h0420, "sw_both_edges");
    switches_raw = 6'b000000;
    repeat (5) @(negedge clk);
    rd(REG_EVENT, 16'h0020, "sw5_fall_event");

    // button 2 flag sets on the very edge of an EVENT read
    buttons_raw[2] = 1'b1;
    repeat (5) @(negedge clk);
    rd(REG_EVENT, 16'h0000, "collide_word");
    rd(REG_EVENT, 16'h0004, "collide_next");
    buttons_raw[2] = 1'b0;
    repeat (10) @(negedge clk);

    // reset two cycles into a debounce count of button 1
    buttons_raw[1] = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rd(REG_LEVEL, 16'h0000, "rst_mid_level");
    rd(REG_EVENT, 16'h0000, "rst_mid_event");
    repeat (3) @(negedge clk);
    rd(REG_LEVEL, 16'h0002, "rst_mid_level_late");
    rd(REG_EVENT, 16'h0002, "rst_mid_event_late");
    buttons_raw[1] = 1'b0;

    // hold-to-repeat on the second instance, polling EVENT every cycle
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    rd_sel = REG_EVENT;
    rd_en  = 1'b1;
    buttons_raw[3] = 1'b1;
    tick_q = '{8, 18, 23, 28, 33};
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (data_r !== 16'h0000) begin
        if (tick_q.size() == 0) begin
          check("rep_extra_event", {16'h0, data_r}, 32'h0);
        end else begin
          check("rep_tick_cycle", c, tick_q.pop_front());
          check("rep_tick_word", {16'h0, data_r}, 32'h0008);
        end
      end
      if (c == 28) buttons_raw[3] = 1'b0;
    end
    rd_en = 1'b0;
    check("rep_missing_ticks", tick_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/input_event_unit.md
# input_event_unit

Parametrised front-panel input block for the 16-bit CPU. It conditions N push-buttons and M slide switches:
- buttons get a 2-flop synchroniser and a counter debounce;
- switches get a 2-flop synchroniser.

It keeps sticky per-button press events with optional hold-to-repeat, and an interrupt request. The CPU I/O decoder reads it as two 16-bit registers: live levels and read-to-clear events. It replaces the fixed 5-button / 6-switch level-only input port.

## Interface
Parameters:
- NUM_BUTTONS, 5, button channel count; NUM_BUTTONS + NUM_SWITCHES <= 16
- NUM_SWITCHES, 6, switch channel count
- DB_CYCLES, 65536, consecutive stable synchronised cycles required before a debounced button changes; >= 1
- REPEAT_DELAY, 0, cycles a button must be held before the first repeat event; 0 disables repeat
- REPEAT_PERIOD, 0, cycles between subsequent repeat events; ignored when REPEAT_DELAY = 0; >= 1 when repeat is enabled

Ports:
- clk, in, 1, system clock
- rst, in, 1, synchronous active-high reset
- buttons_raw, in, NUM_BUTTONS, asynchronous button pins
- switches_raw, in, NUM_SWITCHES, asynchronous switch pins
- rd_en, in, 1, one-cycle read strobe from the I/O decoder
- rd_sel, in, 1, register select: 0 = LEVEL, 1 = EVENT
- data_out, out, 16, registered read data
- irq, out, 1, high while any event flag is set

## Operation
- Synchroniser: every raw input passes through 2 flops before any other use.
- Button debounce:
  - Each channel has a stable level `db` and a counter.
  - If the synchronised input equals `db`, the counter clears.
  - Otherwise the counter increments. When it reaches DB_CYCLES-1, `db` flips and the counter clears.
  - Counter width is $clog2(DB_CYCLES+1).
  - Switches are not debounced.
- Bit layout, shared by both registers:
  - Button i sits at bit i.
  - Switch j sits at bit NUM_BUTTONS+NUM_SWITCHES-1-j. With defaults, switch 0 is bit 10 and switch 5 is bit 5.
  - Unused upper bits read 0.
- LEVEL register: debounced buttons plus synchronised switches.
- EVENT register:
  - Button bits are sticky flags. A flag sets on a `db` rising edge and on each repeat tick.
  - Switch bits are sticky flags that set on any synchronised switch transition, in either direction.
- Repeat, per button, when REPEAT_DELAY > 0:
  - The hold counter starts at the rising edge.
  - The first tick fires after REPEAT_DELAY cycles of continuous `db` = 1.
  - Further ticks fire every REPEAT_PERIOD cycles.
  - The counter clears when `db` falls.
- Read:
  - On a clk edge with rd_en = 1, data_out loads the selected register.
  - If rd_sel = 1, all flags returned in that word are cleared on the same edge.
  - A flag whose set condition is true on that same edge stays set (set wins) and is not in the returned word.
- data_out holds its value when rd_en = 0.
- irq = OR of all event flags; registered.
- Reset:
  - Clears synchronisers, `db`, counters, flags, data_out and irq.
  - Switch change detection restarts from 0. Any switch that is on at reset therefore produces one event 2–3 cycles after reset deasserts. This is intended: it reports the power-up state.

## Timing
- Raw button edge to `db` change: 2 cycles of synchronisation plus DB_CYCLES cycles, if the input stays stable.
- `db` rise to EVENT flag set: 1 cycle. Flag set to irq high: 1 cycle.
- Raw switch edge to LEVEL bit: 2 cycles. To EVENT flag: 3 cycles.
- Read latency: data_out is valid the cycle after rd_en. Back-to-back reads are allowed every cycle.
- Reset asserted mid-debounce or mid-repeat: all state returns to reset values on the next edge, and no event is generated.
- Glitch handling: a glitch shorter than DB_CYCLES cycles is absorbed; the counter restarts on each return to `db`.
- Reset values: data_out = 16'h0000, irq = 0.

## Structure
Shared package `io_pkg`:
- REG_LEVEL = 1'b0, REG_EVENT = 1'b1
- IO_DATA_W = 16
- parameter-legality check function (channel sum <= 16, DB_CYCLES >= 1, REPEAT_PERIOD >= 1 when repeat is enabled)

Sub-module `debounce_ch` (parameter DB_CYCLES; ports clk, rst, in_sync, db_out, rise), instantiated NUM_BUTTONS times in a generate loop. Repeat counters, flags and read mux live in the top level.

## Test plan
Use NUM_BUTTONS=5, NUM_SWITCHES=6, DB_CYCLES=4 throughout; repeat disabled unless stated.
- Reset: hold rst 3 cycles with all raw inputs 0 → data_out=0, irq=0. Read LEVEL → 16'h0000.
- Debounce: button 0 bounces 1,0,1 for 1 cycle each, then stays 1 → exactly one event. Read EVENT → 16'h0001, irq falls the cycle after the read. A second EVENT read → 16'h0000.
- Switch mapping: set switches_raw=6'b000001, wait 5 cycles. Read LEVEL → 16'h0400. Read EVENT → 16'h0400.
- Set-wins collision: button 2 rises on the same edge as an EVENT read → the returned word lacks bit 2; the next EVENT read → 16'h0004.
- Repeat: REPEAT_DELAY=10, REPEAT_PERIOD=5. Hold button 3 for 30 cycles past `db` rise and read EVENT after each tick → ticks at cycles 10, 15, 20, 25, each read returning 16'h0008. Release → no further events.
- Reset mid-operation: assert rst at cycle 2 of an active debounce count → no event after release, and LEVEL reads 0 until a full new DB_CYCLES window completes.
